// File: rtl/cpu_linux_mul_arbiter_if.sv
// Requester-side bundle for the shared multiplier arbiter.
// slave = arbiter side, master = requester side.
interface cpu_linux_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src1;
    logic [NUM_REQ*32-1:0] req_src2;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [NUM_REQ*32-1:0] rsp_data;

    modport slave (
        input  req_valid, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cpu_linux_mul_arbiter.sv
// Round-robin share of one pipelined multiply cell; result held 2+MUL_LATENCY... i.e. captured 1+MUL_LATENCY edges after accept.
// Backpressure: a held response blocks only its own requester's next grant; others keep flowing.
module cpu_linux_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    cpu_linux_mul_arbiter_if.slave        bus,
    output logic [31:0]                   mul_src1,
    output logic [31:0]                   mul_src2,
    input  logic [31:0]                   mul_result,
    output logic                          busy
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = 1 + MUL_LATENCY;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        DONE     = 2'd2
    } slot_t;

    slot_t                 slot_q [NUM_REQ];
    slot_t                 slot_d [NUM_REQ];
    logic [IDW-1:0]        ptr_q;
    logic [DEPTH-1:0]      tag_vld_q;
    logic [IDW-1:0]        tag_id_q [DEPTH];
    logic [NUM_REQ*32-1:0] rsp_data_q;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done_vec;
    logic [NUM_REQ-1:0]    rsp_fire;
    logic [NUM_REQ-1:0]    rsp_valid_c;
    logic [IDW-1:0]        grant_idx;
    logic                  accept;
    logic [31:0]           sel_src1;
    logic [31:0]           sel_src2;
    logic                  any_busy;

    always_comb begin
        eligible    = '0;
        done_vec    = '0;
        rsp_valid_c = '0;
        any_busy    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i]    = bus.req_valid[i] && (slot_q[i] == IDLE);
            done_vec[i]    = tag_vld_q[DEPTH-1] && (tag_id_q[DEPTH-1] == IDW'(i));
            rsp_valid_c[i] = (slot_q[i] == DONE);
            if (slot_q[i] != IDLE) begin
                any_busy = 1'b1;
            end
        end
        rsp_fire = rsp_valid_c & bus.rsp_ready;
    end

    // Search begins one past the last winner so every eligible requester is reached within NUM_REQ grants.
    always_comb begin : arb
        int idx;
        idx       = 0;
        accept    = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!accept && eligible[IDW'(idx)]) begin
                accept    = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
        if (accept) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_src1 = bus.req_src1[32*i +: 32];
                sel_src2 = bus.req_src2[32*i +: 32];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                IDLE:     if (grant[i])    slot_d[i] = INFLIGHT;
                INFLIGHT: if (done_vec[i]) slot_d[i] = DONE;
                DONE:     if (rsp_fire[i]) slot_d[i] = IDLE;
                default:                   slot_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= IDW'(NUM_REQ - 1);
            mul_src1   <= '0;
            mul_src2   <= '0;
            tag_vld_q  <= '0;
            rsp_data_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            if (accept) begin
                ptr_q    <= grant_idx;
                mul_src1 <= sel_src1;
                mul_src2 <= sel_src2;
            end
            // Tag stage DEPTH-1 lines up with mul_result for the op issued DEPTH edges earlier.
            tag_vld_q   <= {tag_vld_q[DEPTH-2:0], accept};
            tag_id_q[0] <= grant_idx;
            for (int s = 1; s < DEPTH; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_vec[i]) begin
                    rsp_data_q[32*i +: 32] <= mul_result;
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = any_busy;

endmodule

// File: tb/tb_cpu_linux_mul_arbiter.sv
// Scoreboard bench for the shared multiplier arbiter with a one-cycle multiply cell model.
module tb_cpu_linux_mul_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     mul_src1, mul_src2, mul_result;
    logic            busy;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    rsp_ready = '0;
    logic [N*32-1:0] src1_bus = '0;
    logic [N*32-1:0] src2_bus = '0;

    always #5 clk = ~clk;

    cpu_linux_mul_arbiter_if #(.NUM_REQ(N)) bus ();
    assign bus.req_valid = req_valid;
    assign bus.req_src1  = src1_bus;
    assign bus.req_src2  = src2_bus;
    assign bus.rsp_ready = rsp_ready;

    cpu_linux_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_result (mul_result),
        .busy       (busy)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) mul_result <= '0;
        else       mul_result <= mul_src1 * mul_src2;
    end

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] op_a [N][$];
    logic [31:0] op_b [N][$];
    logic [31:0] exp_q [N][$];
    int          acc_cyc_q [N][$];
    int          grant_log [$];
    int          grant_cyc [$];
    logic [N-1:0] acc_seen = '0;
    logic [N-1:0] seen_vld = '0;
    logic [31:0] last_rsp [N];
    int          rsp_cnt [N] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [31:0] prod;
        if (reset) begin
            acc_seen = '0;
            seen_vld = '0;
        end else begin
            acc_seen = req_valid & bus.req_ready;
            n_checks++;
            if ($countones(bus.req_ready) <= 1 && (bus.req_ready & ~req_valid) == '0 &&
                (bus.req_ready & bus.rsp_valid) == '0) n_pass++;
            else $display("FAIL grant_rule cyc=%0d req_ready=%b req_valid=%b rsp_valid=%b",
                          cyc, bus.req_ready, req_valid, bus.rsp_valid);
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    prod = src1_bus[32*i +: 32] * src2_bus[32*i +: 32];
                    exp_q[i].push_back(prod);
                    acc_cyc_q[i].push_back(cyc);
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
                if (bus.rsp_valid[i] && !seen_vld[i]) begin
                    seen_vld[i] = 1'b1;
                    n_checks++;
                    if (acc_cyc_q[i].size() > 0 && cyc - acc_cyc_q[i][0] == 3) n_pass++;
                    else $display("FAIL rsp_latency req%0d got %0d cycles (pending=%0d) expected 3",
                                  i, (acc_cyc_q[i].size() > 0) ? cyc - acc_cyc_q[i][0] : -1,
                                  acc_cyc_q[i].size());
                end
                if (bus.rsp_valid[i] && rsp_ready[i]) begin
                    n_checks++;
                    if (exp_q[i].size() > 0 && bus.rsp_data[32*i +: 32] === exp_q[i][0]) n_pass++;
                    else $display("FAIL rsp_data req%0d got %h expected %h (pending=%0d)", i,
                                  bus.rsp_data[32*i +: 32],
                                  (exp_q[i].size() > 0) ? exp_q[i][0] : 32'hx, exp_q[i].size());
                    if (exp_q[i].size() > 0) begin
                        void'(exp_q[i].pop_front());
                        void'(acc_cyc_q[i].pop_front());
                    end
                    last_rsp[i] = bus.rsp_data[32*i +: 32];
                    rsp_cnt[i]++;
                    seen_vld[i] = 1'b0;
                end
            end
        end
    end

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += op_a[i].size() + exp_q[i].size();
        return s;
    endfunction

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i].push_back(a);
        op_b[i].push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc_seen[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && op_a[i].size() > 0) begin
                src1_bus[32*i +: 32] = op_a[i].pop_front();
                src2_bus[32*i +: 32] = op_b[i].pop_front();
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((pending() != 0 || req_valid != '0 || busy) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (k < budget) n_pass++;
        else $display("FAIL drain_timeout got %0d cycles expected under %0d", k, budget);
    endtask

    task automatic clear_tb();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i].delete();
            op_b[i].delete();
            exp_q[i].delete();
            acc_cyc_q[i].delete();
        end
        grant_log.delete();
        grant_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_tb();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.req_ready === '0) n_pass++; else $display("FAIL rst_req_ready got %b expected 0", bus.req_ready);
        n_checks++; if (bus.rsp_valid === '0) n_pass++; else $display("FAIL rst_rsp_valid got %b expected 0", bus.rsp_valid);
        n_checks++; if (bus.rsp_data === '0) n_pass++; else $display("FAIL rst_rsp_data got %h expected 0", bus.rsp_data);
        n_checks++; if (mul_src1 === 32'h0) n_pass++; else $display("FAIL rst_mul_src1 got %h expected 0", mul_src1);
        n_checks++; if (mul_src2 === 32'h0) n_pass++; else $display("FAIL rst_mul_src2 got %h expected 0", mul_src2);
        n_checks++; if (busy === 1'b0) n_pass++; else $display("FAIL rst_busy got %b expected 0", busy);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int n0;
        rsp_ready = '1;
        n0 = grant_log.size();
        load(0, 32'h0001_0003, 32'h0000_0005);
        wait_drain(40);
        n_checks++; if (grant_log.size() == n0 + 1 && grant_log[n0] == 0) n_pass++;
        else $display("FAIL single_grant got %0d grants expected one to req0", grant_log.size() - n0);
        n_checks++; if (last_rsp[0] === 32'h0005_000F) n_pass++; else $display("FAIL single_data got %h expected 0005000f", last_rsp[0]);
        n_checks++; if (mul_src1 === 32'h0001_0003 && mul_src2 === 32'h5) n_pass++;
        else $display("FAIL idle_mul_src_hold got %h/%h expected 00010003/00000005", mul_src1, mul_src2);
        n_checks++; if (busy === 1'b0) n_pass++; else $display("FAIL single_busy got %b expected 0", busy);
    endtask

    task automatic test_all_four();
        do_reset();
        rsp_ready = '1;
        for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
        wait_drain(40);
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (grant_log.size() > k && grant_log[k] == k && (k == 0 || grant_cyc[k] - grant_cyc[k-1] == 1)) n_pass++;
            else $display("FAIL all_four_order slot %0d got req%0d expected req%0d on consecutive cycles",
                          k, (grant_log.size() > k) ? grant_log[k] : -1, k);
        end
    endtask

    task automatic test_arith();
        logic [31:0] a [4] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFE};
        logic [31:0] b [4] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0002, 32'h0000_0003};
        logic [31:0] e [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFA};
        rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            load(0, a[k], b[k]);
            wait_drain(40);
            n_checks++;
            if (last_rsp[0] === e[k]) n_pass++;
            else $display("FAIL arith_%0d got %h expected %h", k, last_rsp[0], e[k]);
        end
        for (int k = 0; k < 12; k++) load(k % N, $urandom, $urandom);
        wait_drain(100);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          base, k;
        rsp_ready = 4'b1101;
        load(1, 32'h0000_1234, 32'h0000_0010);
        load(1, 32'h0000_0007, 32'h0000_0009);
        for (int r = 0; r < 5; r++) begin
            load(0, $urandom, $urandom);
            load(2, $urandom, $urandom);
            load(3, $urandom, $urandom);
        end
        k = 0;
        while (!bus.rsp_valid[1] && k < 30) begin step(); k++; end
        n_checks++; if (k < 30) n_pass++; else $display("FAIL bp_wait_rsp got timeout expected rsp_valid[1]");
        held = bus.rsp_data[63:32];
        n_checks++; if (held === 32'h0001_2340) n_pass++; else $display("FAIL bp_data got %h expected 00012340", held);
        base = rsp_cnt[0] + rsp_cnt[2] + rsp_cnt[3];
        repeat (10) begin
            step();
            n_checks++;
            if (bus.rsp_valid[1] === 1'b1 && bus.rsp_data[63:32] === held) n_pass++;
            else $display("FAIL bp_hold got vld=%b data=%h expected 1/%h", bus.rsp_valid[1], bus.rsp_data[63:32], held);
            n_checks++;
            if (bus.req_ready[1] === 1'b0) n_pass++;
            else $display("FAIL bp_no_grant got req_ready[1]=%b expected 0", bus.req_ready[1]);
        end
        n_checks++;
        if (rsp_cnt[0] + rsp_cnt[2] + rsp_cnt[3] > base) n_pass++;
        else $display("FAIL bp_others_served got 0 responses expected >0");
        rsp_ready = '1;
        wait_drain(100);
    endtask

    task automatic test_reset_mid();
        int n0, k;
        rsp_ready = '1;
        n0 = grant_log.size();
        load(0, 32'h0000_0011, 32'h0000_0022);
        load(1, 32'h0000_0033, 32'h0000_0044);
        k = 0;
        while (grant_log.size() - n0 < 2 && k < 10) begin step(); k++; end
        n_checks++; if (k < 10 && busy === 1'b1) n_pass++; else $display("FAIL mid_inflight got busy=%b expected 1", busy);
        reset = 1'b1;
        clear_tb();
        #1;
        n_checks++; if (bus.req_ready === '0) n_pass++; else $display("FAIL mid_req_ready got %b expected 0", bus.req_ready);
        n_checks++; if (bus.rsp_valid === '0) n_pass++; else $display("FAIL mid_rsp_valid got %b expected 0", bus.rsp_valid);
        n_checks++; if (bus.rsp_data === '0) n_pass++; else $display("FAIL mid_rsp_data got %h expected 0", bus.rsp_data);
        n_checks++; if (mul_src1 === '0 && mul_src2 === '0) n_pass++; else $display("FAIL mid_mul_src got %h/%h expected 0/0", mul_src1, mul_src2);
        n_checks++; if (busy === 1'b0) n_pass++; else $display("FAIL mid_busy got %b expected 0", busy);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin
            step();
            n_checks++;
            if (bus.rsp_valid === '0) n_pass++; else $display("FAIL mid_stale_rsp got %b expected 0", bus.rsp_valid);
        end
        load(0, 32'h0000_0100, 32'h0000_0300);
        wait_drain(40);
        n_checks++; if (last_rsp[0] === 32'h0003_0000) n_pass++; else $display("FAIL mid_after data got %h expected 00030000", last_rsp[0]);
    endtask

    task automatic test_round_robin();
        int n0, zeros;
        do_reset();
        rsp_ready = '1;
        for (int k = 0; k < 50; k++) begin
            load(0, $urandom, $urandom);
            load(2, $urandom, $urandom);
        end
        n0 = grant_log.size();
        wait_drain(1000);
        n_checks++;
        if (grant_log.size() - n0 == 100) n_pass++;
        else $display("FAIL rr_count got %0d grants expected 100", grant_log.size() - n0);
        zeros = 0;
        for (int k = n0; k < grant_log.size(); k++) begin
            if (grant_log[k] == 0) zeros++;
            if (k > n0) begin
                n_checks++;
                if (grant_log[k] != grant_log[k-1] && (grant_log[k] == 0 || grant_log[k] == 2)) n_pass++;
                else $display("FAIL rr_alternate at %0d got req%0d after req%0d expected the other of 0/2",
                              k - n0, grant_log[k], grant_log[k-1]);
            end
        end
        n_checks++;
        if (zeros == 50) n_pass++; else $display("FAIL rr_fairness got %0d req0 grants expected 50", zeros);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_arith();
        test_backpressure();
        test_reset_mid();
        test_round_robin();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected completion within 20000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
